// File: rtl/program_ram_pkg.sv
// Shared constants and state encoding for the program/data memory and its CPU-side users.
package program_ram_pkg;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 14;
  localparam int unsigned WDATA_W = 8;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } ram_state_e;

endpackage

// File: rtl/prog_loader.sv
// LOAD/RUN sequencer: accepts loader words into the array, then hands the memory to the CPU.
// With RAM_INIT_EN defined, reset lands directly in RUN with a full word count.
module prog_loader
  import program_ram_pkg::ram_state_e;
  import program_ram_pkg::LOAD;
  import program_ram_pkg::RUN;
#(
  parameter int unsigned DEPTH  = program_ram_pkg::DEPTH,
  parameter int unsigned ADDR_W = program_ram_pkg::ADDR_W,
  parameter int unsigned DATA_W = program_ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic              load_ready,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_count,
  output logic              access_err,
  output logic              run,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
`ifdef RAM_INIT_EN
  localparam ram_state_e      RST_STATE = RUN;
  localparam logic [ADDR_W:0] RST_CNT   = (ADDR_W + 1)'(DEPTH);
`else
  localparam ram_state_e      RST_STATE = LOAD;
  localparam logic [ADDR_W:0] RST_CNT   = '0;
`endif

  ram_state_e      state_q, state_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            err_q, err_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    if (state_q == LOAD) begin
      if (cpu_rd || cpu_wr) err_d = 1'b1;
      if (load_valid) begin
        mem_we  = 1'b1;
        count_d = count_q + 1'b1;
        // The word filling the last slot ends loading even without loadLast.
        if (load_last || (count_q == LAST_CNT)) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      count_q <= RST_CNT;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign run        = (state_q == RUN);
  assign load_ready = (state_q == LOAD);
  assign cpu_hold   = (state_q == LOAD);
  assign load_count = count_q;
  assign access_err = err_q;
  assign mem_addr   = count_q[ADDR_W-1:0];
  assign mem_wdata  = load_data;

endmodule

// File: rtl/program_ram.sv
// 64x14 program/data memory: loader fill after reset, then zero-latency CPU fetch/LDR/STR.
// Define RAM_INIT_EN to preload from INIT_IMAGE and skip the loader phase.
module program_ram #(
  parameter int unsigned DEPTH     = program_ram_pkg::DEPTH,
  parameter int unsigned ADDR_W    = program_ram_pkg::ADDR_W,
  parameter int unsigned DATA_W    = program_ram_pkg::DATA_W,
  parameter int unsigned WDATA_W   = program_ram_pkg::WDATA_W,
  parameter string       INIT_FILE = "program.mem",
  parameter logic [DEPTH*DATA_W-1:0] INIT_IMAGE = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               readRAM,
  input  logic               writeRAM,
  input  logic [ADDR_W-1:0]  address,
  input  logic [WDATA_W-1:0] ramWriteData,
  output logic [DATA_W-1:0]  RAMdata,
  input  logic               loadValid,
  input  logic [DATA_W-1:0]  loadData,
  input  logic               loadLast,
  output logic               loadReady,
  output logic               cpuHold,
  output logic [ADDR_W:0]    loadCount,
  output logic               accessErr
);

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef RAM_INIT_EN
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem[i] = INIT_IMAGE[i*DATA_W +: DATA_W];
    end
  end
`endif

  logic              run;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] wr_ext;
  logic [DATA_W-1:0] hold_q, hold_d;

  prog_loader #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_valid (loadValid),
    .load_data  (loadData),
    .load_last  (loadLast),
    .cpu_rd     (readRAM),
    .cpu_wr     (writeRAM),
    .load_ready (loadReady),
    .cpu_hold   (cpuHold),
    .load_count (loadCount),
    .access_err (accessErr),
    .run        (run),
    .mem_we     (ld_we),
    .mem_addr   (ld_addr),
    .mem_wdata  (ld_wdata)
  );

  assign rd_word = mem[address];
  assign wr_ext  = {{(DATA_W - WDATA_W){1'b0}}, ramWriteData};

  // Array is not reset; loader and CPU writes never overlap because they are gated by state.
  always_ff @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_wdata;
    end else if (run && writeRAM) begin
      mem[address] <= wr_ext;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (run && readRAM) hold_d = rd_word;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  // Live read during the strobe, held fetch afterwards; read-before-write on a combined strobe.
  assign RAMdata = (run && readRAM) ? rd_word : hold_q;

endmodule

// File: tb/tb_program_ram.sv
// Directed, table-driven bench for program_ram (default build, RAM_INIT_EN undefined).
module tb_program_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        readRAM;
  logic        writeRAM;
  logic [5:0]  address;
  logic [7:0]  ramWriteData;
  logic [13:0] RAMdata;
  logic        loadValid;
  logic [13:0] loadData;
  logic        loadLast;
  logic        loadReady;
  logic        cpuHold;
  logic [6:0]  loadCount;
  logic        accessErr;

  int n_cmp = 0;
  int n_bad = 0;

  program_ram #(
    .DEPTH   (64),
    .ADDR_W  (6),
    .DATA_W  (14),
    .WDATA_W (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .readRAM      (readRAM),
    .writeRAM     (writeRAM),
    .address      (address),
    .ramWriteData (ramWriteData),
    .RAMdata      (RAMdata),
    .loadValid    (loadValid),
    .loadData     (loadData),
    .loadLast     (loadLast),
    .loadReady    (loadReady),
    .cpuHold      (cpuHold),
    .loadCount    (loadCount),
    .accessErr    (accessErr)
  );

  always #5 clk = ~clk;

  // Inputs applied for one cycle; expectations are the outputs just before that cycle's edge.
  typedef struct {
    string       tag;
    logic        rst, rd, wr;
    logic [5:0]  addr;
    logic [7:0]  wd;
    logic        lv;
    logic [13:0] ld;
    logic        ll;
    logic        chk;
    logic [13:0] e_data;
    logic        e_rdy, e_hold;
    logic [6:0]  e_cnt;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(string tag, logic r, logic rd, logic wr, logic [5:0] a,
                              logic [7:0] wd, logic lv, logic [13:0] ld, logic ll, logic chk,
                              logic [13:0] ed, logic erdy, logic ehold, logic [6:0] ecnt,
                              logic eerr);
    vec_t v;
    v.tag = tag; v.rst = r; v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd;
    v.lv = lv; v.ld = ld; v.ll = ll; v.chk = chk;
    v.e_data = ed; v.e_rdy = erdy; v.e_hold = ehold; v.e_cnt = ecnt; v.e_err = eerr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    rst = v.rst; readRAM = v.rd; writeRAM = v.wr; address = v.addr;
    ramWriteData = v.wd; loadValid = v.lv; loadData = v.ld; loadLast = v.ll;
    #2;
    if (v.chk) begin
      chk({v.tag, ".RAMdata"},   32'(RAMdata),   32'(v.e_data));
      chk({v.tag, ".loadReady"}, 32'(loadReady), 32'(v.e_rdy));
      chk({v.tag, ".cpuHold"},   32'(cpuHold),   32'(v.e_hold));
      chk({v.tag, ".loadCount"}, 32'(loadCount), 32'(v.e_cnt));
      chk({v.tag, ".accessErr"}, 32'(accessErr), 32'(v.e_err));
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; readRAM = 1'b0; writeRAM = 1'b0; address = '0; ramWriteData = '0;
    loadValid = 1'b0; loadData = '0; loadLast = 1'b0;

    //            tag     rst rd wr addr wd    lv ld        ll chk data      rdy hold cnt err
    tbl.push_back(mk("rst",  1, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 0, 14'h0000, 1, 1, 0, 0));
    tbl.push_back(mk("rstv", 0, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0000, 1, 1, 0, 0));
    tbl.push_back(mk("ld0",  0, 0, 0, 0, 8'h00, 1, 14'h1A05, 0, 1, 14'h0000, 1, 1, 0, 0));
    tbl.push_back(mk("ld1",  0, 0, 0, 0, 8'h00, 1, 14'h0C3F, 0, 1, 14'h0000, 1, 1, 1, 0));
    tbl.push_back(mk("ld2",  0, 0, 0, 0, 8'h00, 1, 14'h2001, 1, 1, 14'h0000, 1, 1, 2, 0));
    tbl.push_back(mk("run",  0, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0000, 0, 0, 3, 0));
    tbl.push_back(mk("ldx",  0, 0, 0, 0, 8'h00, 1, 14'h3FFF, 0, 1, 14'h0000, 0, 0, 3, 0));
    tbl.push_back(mk("rd1",  0, 1, 0, 1, 8'h00, 0, 14'h0000, 0, 1, 14'h0C3F, 0, 0, 3, 0));
    tbl.push_back(mk("hld1", 0, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0C3F, 0, 0, 3, 0));
    tbl.push_back(mk("hld2", 0, 0, 0, 7, 8'h00, 0, 14'h0000, 0, 1, 14'h0C3F, 0, 0, 3, 0));
    tbl.push_back(mk("hld3", 0, 0, 0, 2, 8'h00, 0, 14'h0000, 0, 1, 14'h0C3F, 0, 0, 3, 0));
    tbl.push_back(mk("rd0",  0, 1, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h1A05, 0, 0, 3, 0));
    tbl.push_back(mk("rd2",  0, 1, 0, 2, 8'h00, 0, 14'h0000, 0, 1, 14'h2001, 0, 0, 3, 0));
    tbl.push_back(mk("wrA",  0, 0, 1,10, 8'hA7, 0, 14'h0000, 0, 1, 14'h2001, 0, 0, 3, 0));
    tbl.push_back(mk("rdA",  0, 1, 0,10, 8'h00, 0, 14'h0000, 0, 1, 14'h00A7, 0, 0, 3, 0));
    tbl.push_back(mk("rwA",  0, 1, 1,10, 8'h55, 0, 14'h0000, 0, 1, 14'h00A7, 0, 0, 3, 0));
    tbl.push_back(mk("hldA", 0, 0, 0,10, 8'h00, 0, 14'h0000, 0, 1, 14'h00A7, 0, 0, 3, 0));
    tbl.push_back(mk("rdA2", 0, 1, 0,10, 8'h00, 0, 14'h0000, 0, 1, 14'h0055, 0, 0, 3, 0));
    tbl.push_back(mk("wwA1", 0, 0, 1,10, 8'h11, 0, 14'h0000, 0, 1, 14'h0055, 0, 0, 3, 0));
    tbl.push_back(mk("wwA2", 0, 0, 1,10, 8'h22, 0, 14'h0000, 0, 1, 14'h0055, 0, 0, 3, 0));
    tbl.push_back(mk("rdA3", 0, 1, 0,10, 8'h00, 0, 14'h0000, 0, 1, 14'h0022, 0, 0, 3, 0));
    foreach (tbl[i]) step(tbl[i]);

    // Reset during RUN, then CPU strobes while loading set the sticky error without touching memory.
    step(mk("rrun",  1, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0022, 0, 0, 3, 0));
    step(mk("rld",   0, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0000, 1, 1, 0, 0));
    step(mk("erd",   0, 1, 0, 2, 8'h00, 0, 14'h0000, 0, 1, 14'h0000, 1, 1, 0, 0));
    step(mk("ewr",   0, 0, 1, 2, 8'h77, 0, 14'h0000, 0, 1, 14'h0000, 1, 1, 0, 1));
    step(mk("estk",  0, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0000, 1, 1, 0, 1));
    step(mk("eld",   0, 0, 0, 0, 8'h00, 1, 14'h0123, 1, 1, 14'h0000, 1, 1, 0, 1));
    step(mk("erd2",  0, 1, 0, 2, 8'h00, 0, 14'h0000, 0, 1, 14'h2001, 0, 0, 1, 1));
    step(mk("erd0",  0, 1, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0123, 0, 0, 1, 1));

    // Reset after two loaded words restarts at address 0; the second word survives.
    step(mk("mrst",  1, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 0));
    step(mk("m0",    0, 0, 0, 0, 8'h00, 1, 14'h1111, 0, 1, 14'h0000, 1, 1, 0, 0));
    step(mk("m1",    0, 0, 0, 0, 8'h00, 1, 14'h2222, 0, 1, 14'h0000, 1, 1, 1, 0));
    step(mk("mrst2", 1, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0000, 1, 1, 2, 0));
    step(mk("m2",    0, 0, 0, 0, 8'h00, 1, 14'h0333, 1, 1, 14'h0000, 1, 1, 0, 0));
    step(mk("mrun",  0, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0000, 0, 0, 1, 0));
    step(mk("mrd0",  0, 1, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0333, 0, 0, 1, 0));
    step(mk("mrd1",  0, 1, 0, 1, 8'h00, 0, 14'h0000, 0, 1, 14'h2222, 0, 0, 1, 0));

    // Full 64-word fill without loadLast; a 65th word is ignored.
    step(mk("frst",  1, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 0, 14'h0000, 0, 0, 0, 0));
    for (int i = 0; i < 64; i++)
      step(mk($sformatf("f%0d", i), 0, 0, 0, 0, 8'h00, 1, 14'(14'h0100 + i), 0, 1,
              14'h0000, 1, 1, 7'(i), 0));
    step(mk("f64",   0, 0, 0, 0, 8'h00, 1, 14'h3ABC, 0, 1, 14'h0000, 0, 0, 64, 0));
    step(mk("f65",   0, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0000, 0, 0, 64, 0));
    step(mk("frd0",  0, 1, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h0100, 0, 0, 64, 0));
    step(mk("frd37", 0, 1, 0,37, 8'h00, 0, 14'h0000, 0, 1, 14'h0125, 0, 0, 64, 0));
    step(mk("frd63", 0, 1, 0,63, 8'h00, 0, 14'h0000, 0, 1, 14'h013F, 0, 0, 64, 0));
    step(mk("fhld",  0, 0, 0, 0, 8'h00, 0, 14'h0000, 0, 1, 14'h013F, 0, 0, 64, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
